// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared types and constants for the two-requester ram arbiter.
//               Holds the FSM state encoding, requester ids and the default
//               address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Requester ids; the id doubles as the index into the request vector.
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_rr_arb2
// Description : Combinational two-way round-robin pick. A lone requester
//               always wins; on a tie the requester that did not win last
//               time is chosen.
// Ports       : req_i  [1:0] in  request vector, bit n = requester n
//               last_i       in  id of the previous winner
//               gnt_o  [1:0] out one-hot grant (zero when no request)
//               id_o         out id of the chosen requester
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);

    always_comb begin
        id_o  = REQ_M0;
        gnt_o = 2'b00;
        case (req_i)
            2'b01: id_o = REQ_M0;
            2'b10: id_o = REQ_M1;
            2'b11: id_o = (last_i == REQ_M0) ? REQ_M1 : REQ_M0;
            default: id_o = REQ_M0;
        endcase
        if (|req_i) begin
            gnt_o = (id_o == REQ_M1) ? 2'b10 : 2'b01;
        end
    end

endmodule : ram_arbiter_rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares a single-port ram between m0 (instruction fetch) and
//               m1 (load/store). Round-robin, one transaction in flight:
//               grant -> one ram access cycle -> one response cycle.
// Ports       : clk, rst_ (async, active-high)
//               mX_req_i/we_i/addr_i/wdata_i  requester X command (X=0,1)
//               mX_gnt_o                       command accepted (comb.)
//               mX_rvalid_o/rdata_o            one-cycle response
//               ram_we_o/addr_o/data_o         to ram, driven in ACCESS only
//               ram_data_i                     combinational ram read data
//               busy_o                         transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              busy_o
);

    arb_state_e        state_q,     state_d;
    logic              last_gnt_q,  last_gnt_d;
    logic              lat_we_q,    lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q,  lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              lat_id_q,    lat_id_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;

    logic [1:0]        w_arb_gnt;
    logic              w_arb_id;
    logic              w_arb_open;
    logic              w_accept;
    logic              w_access;
    logic              w_resp;

    ram_arbiter_rr_arb2 u_rr_arb2 (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (last_gnt_q),
        .gnt_o  (w_arb_gnt),
        .id_o   (w_arb_id)
    );

    // Grants are offered only when the ram is free of a pending access
    // (IDLE, or RESP where the previous access has already completed).
    assign w_arb_open = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
    assign w_accept   = w_arb_open && (|w_arb_gnt);
    assign w_access   = (state_q == ARB_ACCESS);
    assign w_resp     = (state_q == ARB_RESP);

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_id_d    = lat_id_q;
        rdata_d     = rdata_q;

        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (w_accept) begin
                    state_d     = ARB_ACCESS;
                    last_gnt_d  = w_arb_id;
                    lat_id_d    = w_arb_id;
                    lat_we_d    = (w_arb_id == REQ_M1) ? m1_we_i    : m0_we_i;
                    lat_addr_d  = (w_arb_id == REQ_M1) ? m1_addr_i  : m0_addr_i;
                    lat_wdata_d = (w_arb_id == REQ_M1) ? m1_wdata_i : m0_wdata_i;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                // Writes answer with zero data so the ack carries no stale read.
                rdata_d = lat_we_q ? '0 : ram_data_i;
                state_d = ARB_RESP;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q     <= ARB_IDLE;
            last_gnt_q  <= REQ_M1;  // m0 wins the first tie
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_id_q    <= REQ_M0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_id_q    <= lat_id_d;
            rdata_q     <= rdata_d;
        end
    end

    // Grant is combinational from the requests; gate with reset so an
    // asserted reset silences every output immediately.
    assign m0_gnt_o    = !rst_ && w_accept && w_arb_gnt[0];
    assign m1_gnt_o    = !rst_ && w_accept && w_arb_gnt[1];

    assign m0_rvalid_o = w_resp && (lat_id_q == REQ_M0);
    assign m1_rvalid_o = w_resp && (lat_id_q == REQ_M1);
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;

    assign ram_we_o    = w_access && lat_we_q;
    assign ram_addr_o  = w_access ? lat_addr_q  : '0;
    assign ram_data_o  = w_access ? lat_wdata_q : '0;

    assign busy_o      = (state_q != ARB_IDLE);

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. A reference model of the
//               arbitration rules predicts grants, ram cycles and responses;
//               expected responses go to a queue that a separate monitor
//               drains whenever a response pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_;
    logic          mreq   [2];
    logic          mwe    [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          ram_we_o, busy_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .m0_req_i    (mreq[0]),
        .m0_we_i     (mwe[0]),
        .m0_addr_i   (maddr[0]),
        .m0_wdata_i  (mwdata[0]),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (mreq[1]),
        .m1_we_i     (mwe[1]),
        .m1_addr_i   (maddr[1]),
        .m1_wdata_i  (mwdata[1]),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_rdata),
        .busy_o      (busy_o)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0103_0507);
    endfunction

    // Small ram behind the arbiter: 16 words, combinational read.
    logic [DW-1:0] mem [16];
    bit            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (ram_we_o) begin
            mem[ram_addr_o[3:0]] <= ram_data_o;
        end
    end
    assign ram_rdata = mem[ram_addr_o[3:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit            id;
        logic [DW-1:0] data;
        int            due;
    } resp_t;
    resp_t exp_q[$];

    logic [DW-1:0] shadow [16];
    bit            m_acc, m_resp, m_last;
    logic          m_acc_we;
    logic [AW-1:0] m_acc_addr;
    logic [DW-1:0] m_acc_data;

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        m_acc = 0; m_resp = 0; m_last = 1;
    end

    // Model: a transaction occupies the ram the cycle after its grant and
    // answers the cycle after that; grants are possible whenever the ram is
    // not being accessed. Ties go to the requester that did not win last.
    always @(negedge clk) begin
        bit eg [2];
        bit w;
        resp_t r;
        if (rst_) begin
            exp_q.delete();
            m_acc = 0; m_resp = 0; m_last = 1;
        end else begin
            check("busy", busy_o, m_acc | m_resp);
            if (m_acc) begin
                check("ram_we",   ram_we_o,   m_acc_we);
                check("ram_addr", ram_addr_o, m_acc_addr);
                check("ram_data", ram_data_o, m_acc_data);
            end else begin
                check("ram_quiet", {ram_we_o, ram_addr_o, ram_data_o}, 0);
            end
            eg[0] = 0; eg[1] = 0; w = 0;
            if (!m_acc) begin
                if (mreq[0] && mreq[1]) w = !m_last;
                else                    w = mreq[1];
                if (mreq[0] || mreq[1]) eg[w] = 1;
            end
            check("m0_gnt", m0_gnt_o, eg[0]);
            check("m1_gnt", m1_gnt_o, eg[1]);
            m_resp = m_acc;
            m_acc  = 0;
            if (eg[0] || eg[1]) begin
                m_acc      = 1;
                m_acc_we   = mwe[w];
                m_acc_addr = maddr[w];
                m_acc_data = mwdata[w];
                r.id   = w;
                r.data = mwe[w] ? '0 : shadow[maddr[w][3:0]];
                r.due  = cyc + 2;
                exp_q.push_back(r);
                if (mwe[w]) shadow[maddr[w][3:0]] = mwdata[w];
                m_last = w;
            end
        end
    end

    // Monitor: pops an expectation whenever a response pulse appears.
    always @(negedge clk) begin
        resp_t e;
        if (!rst_) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("rvalid_missing", exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            check("rvalid_both", m0_rvalid_o & m1_rvalid_o, 0);
            if (m0_rvalid_o || m1_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", {m1_rvalid_o, m0_rvalid_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id",   m1_rvalid_o, e.id);
                    check("resp_cyc",  cyc, e.due);
                    check("resp_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.data);
                    check("other_rdata", m1_rvalid_o ? m0_rdata_o : m1_rdata_o, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic new_fields(input int m);
        mwe[m]    = 1'($urandom_range(0, 1));
        maddr[m]  = AW'($urandom_range(0, 15));
        mwdata[m] = $urandom;
    endtask

    task automatic do_txn(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        mwe[m] = we; maddr[m] = a; mwdata[m] = d; mreq[m] = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = (m == 1) ? m1_gnt_o : m0_gnt_o;
            tick();
        end
        check("gnt_timeout", got, 1);
        mreq[m] = 0;
    endtask

    task automatic rand_cycle(input bit hold);
        bit g [2];
        @(negedge clk);
        g[0] = m0_gnt_o; g[1] = m1_gnt_o;
        tick();
        for (int m = 0; m < 2; m++) begin
            if (mreq[m] && g[m]) begin
                mreq[m] = hold || ($urandom_range(0, 1) == 1);
                if (mreq[m]) new_fields(m);
            end else if (mreq[m]) begin
                if (!hold && $urandom_range(0, 7) == 0) mreq[m] = 0;
            end else if (hold || $urandom_range(0, 1) == 1) begin
                new_fields(m);
                mreq[m] = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_ = 1;
        repeat (2) @(posedge clk);
        #1 rst_ = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 0; mwe[m] = 0; maddr[m] = '0; mwdata[m] = '0;
        end
        // Reset with a request pending: everything must stay silent.
        rst_ = 1; mreq[0] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",    {m1_gnt_o, m0_gnt_o}, 0);
        check("rst_rvalid", {m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o}, 0);
        check("rst_ram",    {ram_we_o, ram_addr_o, ram_data_o}, 0);
        check("rst_busy",   busy_o, 0);
        mreq[0] = 0;
        tick(); rst_ = 0;
        repeat (3) tick();

        // m1 write then read-back of address 8.
        do_txn(1, 1'b1, 32'd8, 32'h42);
        repeat (2) tick();
        do_txn(1, 1'b0, 32'd8, 32'h0);
        repeat (3) tick();

        // Both requesters from reset, held high: strict alternation.
        do_reset();
        new_fields(0); new_fields(1);
        mreq[0] = 1; mreq[1] = 1;
        repeat (12) rand_cycle(1'b1);
        mreq[0] = 0; mreq[1] = 0;
        repeat (3) tick();

        // m0 raises and withdraws while m1 owns the bus.
        mwe[1] = 0; maddr[1] = 32'd2; mreq[1] = 1;
        @(negedge clk); tick();           // m1 granted, now in ACCESS
        mreq[1] = 0;
        mwe[0] = 0; maddr[0] = 32'd3; mreq[0] = 1;
        tick();                           // RESP: m0 already gone
        mreq[0] = 0;
        repeat (3) tick();

        // Randomised traffic with withdrawals.
        repeat (300) rand_cycle(1'b0);
        mreq[0] = 0; mreq[1] = 0;
        repeat (4) tick();

        // Reset during the ACCESS cycle of a read.
        mwe[0] = 0; maddr[0] = 32'd5; mwdata[0] = 32'h1234_5678; mreq[0] = 1;
        @(negedge clk);
        @(posedge clk); #1 mreq[0] = 0;
        #1 rst_ = 1;
        #1;
        check("midrst_ram",  {ram_we_o, ram_addr_o, ram_data_o}, 0);
        check("midrst_busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_ = 0;
        repeat (3) tick();
        do_txn(0, 1'b0, 32'd5, 32'h0);
        repeat (4) tick();

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
